// File: rtl/rab_inv_pkg.sv
// rab_inv_pkg: shared constants and types for the RAB invalidation requester.
//   - register offsets of the RAB invalidation block, relative to the config base
//   - AXI-Lite response codes and a response-error helper
//   - top-level FSM state enum
// Ports: none (package).
package rab_inv_pkg;

  localparam logic [7:0] INV_MIN_OFS    = 8'h08;
  localparam logic [7:0] INV_MAX_OFS    = 8'h10;
  localparam logic [7:0] INV_STATUS_OFS = 8'h18;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrMin  = 3'd1,
    StWrMax  = 3'd2,
    StRdStat = 3'd3,
    StWaitR  = 3'd4,
    StDone   = 3'd5
  } inv_state_e;

  // Any response other than OKAY is treated as a failure of the operation.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RespOkay;
  endfunction

endpackage

// File: rtl/rab_inv_req_if.sv
// rab_inv_req_if: AXI-Lite bus between the invalidation requester and the RAB config port.
// Parameters: AXI_LITE_ADDR_WIDTH, AXI_LITE_DATA_WIDTH.
// Modports:
//   master - initiator side (drives aw/w/ar channels, b_ready, r_ready)
//   slave  - target side (drives ready signals and the b/r response channels)
interface rab_inv_req_if #(
  parameter int unsigned AXI_LITE_ADDR_WIDTH = 32,
  parameter int unsigned AXI_LITE_DATA_WIDTH = 64
) ();

  logic [AXI_LITE_ADDR_WIDTH-1:0]   aw_addr;
  logic                             aw_valid;
  logic                             aw_ready;

  logic [AXI_LITE_DATA_WIDTH-1:0]   w_data;
  logic [AXI_LITE_DATA_WIDTH/8-1:0] w_strb;
  logic                             w_valid;
  logic                             w_ready;

  logic [1:0]                       b_resp;
  logic                             b_valid;
  logic                             b_ready;

  logic [AXI_LITE_ADDR_WIDTH-1:0]   ar_addr;
  logic                             ar_valid;
  logic                             ar_ready;

  logic [AXI_LITE_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                       r_resp;
  logic                             r_valid;
  logic                             r_ready;

  modport master (
    output aw_addr, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_addr, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_addr, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_addr, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/rab_lite_wr_seq.sv
// rab_lite_wr_seq: single AXI-Lite write (AW + W + B) sequencer.
// A start_i pulse latches addr_i/data_i and raises aw_valid, w_valid and b_ready together on
// the next cycle. Each valid drops the cycle after its own handshake; b_ready drops after B.
// done_o pulses (combinationally) in the cycle in which the last of the three handshakes
// completes; err_o is valid with done_o and flags a non-OKAY b_resp.
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   start_i, addr_i,      start a write of data_i to addr_i (only while idle)
//   data_i
//   done_o, err_o         completion pulse and error flag
//   aw_*/w_*/b_*          AXI-Lite write channels, initiator side
module rab_lite_wr_seq
  import rab_inv_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [DataWidth-1:0]   data_i,
  output logic                   done_o,
  output logic                   err_o,
  output logic [AddrWidth-1:0]   aw_addr_o,
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  output logic [DataWidth-1:0]   w_data_o,
  output logic [DataWidth/8-1:0] w_strb_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  input  logic [1:0]             b_resp_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o
);

  logic                 busy_q, busy_d;
  logic                 aw_valid_q, aw_valid_d;
  logic                 w_valid_q, w_valid_d;
  logic                 b_ready_q, b_ready_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic                 b_done_q, b_done_d;
  logic                 b_err_q, b_err_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] data_q, data_d;

  logic aw_hs, w_hs, b_hs;

  assign aw_hs = aw_valid_q & aw_ready_i;
  assign w_hs  = w_valid_q & w_ready_i;
  assign b_hs  = b_ready_q & b_valid_i;

  // Completion counts handshakes happening this cycle, so a B that lands together with the
  // last AW/W handshake still finishes the write in that cycle.
  assign done_o = busy_q & (aw_done_q | aw_hs) & (w_done_q | w_hs) & (b_done_q | b_hs);
  assign err_o  = b_hs ? resp_is_err(b_resp_i) : b_err_q;

  assign aw_addr_o  = addr_q;
  assign aw_valid_o = aw_valid_q;
  assign w_data_o   = data_q;
  assign w_strb_o   = '1;
  assign w_valid_o  = w_valid_q;
  assign b_ready_o  = b_ready_q;

  always_comb begin
    busy_d     = busy_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    b_done_d   = b_done_q;
    b_err_d    = b_err_q;
    addr_d     = addr_q;
    data_d     = data_q;
    if (start_i) begin
      busy_d     = 1'b1;
      aw_valid_d = 1'b1;
      w_valid_d  = 1'b1;
      b_ready_d  = 1'b1;
      aw_done_d  = 1'b0;
      w_done_d   = 1'b0;
      b_done_d   = 1'b0;
      b_err_d    = 1'b0;
      addr_d     = addr_i;
      data_d     = data_i;
    end else begin
      if (aw_hs) begin
        aw_valid_d = 1'b0;
        aw_done_d  = 1'b1;
      end
      if (w_hs) begin
        w_valid_d = 1'b0;
        w_done_d  = 1'b1;
      end
      if (b_hs) begin
        b_ready_d = 1'b0;
        b_done_d  = 1'b1;
        b_err_d   = resp_is_err(b_resp_i);
      end
      if (done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q     <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
      b_err_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      busy_q     <= busy_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      b_done_q   <= b_done_d;
      b_err_q    <= b_err_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: rtl/rab_inv_req.sv
// rab_inv_req: issues one RAB TLB invalidation per request over AXI-Lite.
// Sequence: write min to CFG_BASE+INV_MIN_OFS, write max to CFG_BASE+INV_MAX_OFS (this write
// triggers invalidation), then poll CFG_BASE+INV_STATUS_OFS until bit 0 (busy) reads 0.
// A one-cycle done_o pulse ends every accepted request; err_o flags a bad range (min > max),
// any non-OKAY response or, when enabled, a poll timeout.
// Optional feature macro: RAB_INV_TIMEOUT_EN - give up with an error on the MAX_POLLS-th busy
// status read. Without it, polling continues indefinitely and MAX_POLLS is unused.
// Ports:
//   clk_i, rst_ni                     clock, synchronous active-low reset
//   req_valid_i, req_ready_o          request handshake
//   req_addr_min_i, req_addr_max_i    inclusive invalidation range
//   done_o, err_o                     completion pulse and error flag
//   axi                               AXI-Lite initiator (rab_inv_req_if.master)
module rab_inv_req
  import rab_inv_pkg::*;
#(
  parameter int unsigned                   AXI_LITE_ADDR_WIDTH = 32,
  parameter int unsigned                   AXI_LITE_DATA_WIDTH = 64,
  parameter logic [AXI_LITE_ADDR_WIDTH-1:0] CFG_BASE           = '0,
  parameter int unsigned                   MAX_POLLS           = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [AXI_LITE_DATA_WIDTH-1:0] req_addr_min_i,
  input  logic [AXI_LITE_DATA_WIDTH-1:0] req_addr_max_i,
  output logic                           done_o,
  output logic                           err_o,
  rab_inv_req_if.master                  axi
);

  localparam logic [AXI_LITE_ADDR_WIDTH-1:0] MinAddr =
      CFG_BASE + AXI_LITE_ADDR_WIDTH'(INV_MIN_OFS);
  localparam logic [AXI_LITE_ADDR_WIDTH-1:0] MaxAddr =
      CFG_BASE + AXI_LITE_ADDR_WIDTH'(INV_MAX_OFS);
  localparam logic [AXI_LITE_ADDR_WIDTH-1:0] StatAddr =
      CFG_BASE + AXI_LITE_ADDR_WIDTH'(INV_STATUS_OFS);

  inv_state_e                     state_q, state_d;
  logic [AXI_LITE_DATA_WIDTH-1:0] max_q, max_d;
  logic                           err_q, err_d;

  logic                           wr_start;
  logic [AXI_LITE_ADDR_WIDTH-1:0] wr_addr;
  logic [AXI_LITE_DATA_WIDTH-1:0] wr_data;
  logic                           wr_done;
  logic                           wr_err;

`ifdef RAB_INV_TIMEOUT_EN
  localparam int unsigned PollW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
  logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
  logic             poll_limit;

  // Counter holds the number of busy reads seen so far; the next busy read is the last allowed.
  assign poll_limit = (32'(poll_cnt_q) == (MAX_POLLS - 32'd1));
`endif

  rab_lite_wr_seq #(
    .AddrWidth(AXI_LITE_ADDR_WIDTH),
    .DataWidth(AXI_LITE_DATA_WIDTH)
  ) u_wr_seq (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (wr_start),
    .addr_i    (wr_addr),
    .data_i    (wr_data),
    .done_o    (wr_done),
    .err_o     (wr_err),
    .aw_addr_o (axi.aw_addr),
    .aw_valid_o(axi.aw_valid),
    .aw_ready_i(axi.aw_ready),
    .w_data_o  (axi.w_data),
    .w_strb_o  (axi.w_strb),
    .w_valid_o (axi.w_valid),
    .w_ready_i (axi.w_ready),
    .b_resp_i  (axi.b_resp),
    .b_valid_i (axi.b_valid),
    .b_ready_o (axi.b_ready)
  );

  // Read channel is a pure function of state: AR only in RdStat, R only in WaitR, so AR and AW
  // can never be raised together and only one transaction is ever outstanding.
  assign axi.ar_addr  = StatAddr;
  assign axi.ar_valid = (state_q == StRdStat);
  assign axi.r_ready  = (state_q == StWaitR);

  assign req_ready_o = (state_q == StIdle);
  assign done_o      = (state_q == StDone);
  assign err_o       = (state_q == StDone) & err_q;

  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    err_d    = err_q;
    wr_start = 1'b0;
    wr_addr  = MinAddr;
    wr_data  = req_addr_min_i;
`ifdef RAB_INV_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef RAB_INV_TIMEOUT_EN
        poll_cnt_d = '0;
`endif
        if (req_valid_i) begin
          max_d = req_addr_max_i;
          if (req_addr_min_i > req_addr_max_i) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            // Start fires on the accepting edge so the valids are up on WrMin entry.
            wr_start = 1'b1;
            state_d  = StWrMin;
          end
        end
      end
      StWrMin: begin
        if (wr_done) begin
          if (wr_err) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            wr_start = 1'b1;
            wr_addr  = MaxAddr;
            wr_data  = max_q;
            state_d  = StWrMax;
          end
        end
      end
      StWrMax: begin
        if (wr_done) begin
          if (wr_err) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StRdStat;
          end
        end
      end
      StRdStat: begin
        if (axi.ar_ready) begin
          state_d = StWaitR;
        end
      end
      StWaitR: begin
        if (axi.r_valid) begin
          if (resp_is_err(axi.r_resp)) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (axi.r_data[0]) begin
`ifdef RAB_INV_TIMEOUT_EN
            if (poll_limit) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              poll_cnt_d = poll_cnt_q + PollW'(1);
              state_d    = StRdStat;
            end
`else
            state_d = StRdStat;
`endif
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      max_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      err_q   <= err_d;
    end
  end

`ifdef RAB_INV_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      poll_cnt_q <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_rab_inv_req.sv
// tb_rab_inv_req: directed self-checking bench for rab_inv_req with a small AXI-Lite target.
// The target reacts on the falling clock edge: it retires handshakes seen at the previous
// rising edge, issues B/R responses, sets ready signals and logs the handshakes that the next
// rising edge will complete.
module tb_rab_inv_req;
  import rab_inv_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_min;
  logic [DW-1:0] req_max;
  logic          done;
  logic          err;

  int total = 0;
  int bad = 0;

  rab_inv_req_if #(.AXI_LITE_ADDR_WIDTH(AW), .AXI_LITE_DATA_WIDTH(DW)) axi ();

  rab_inv_req #(
    .AXI_LITE_ADDR_WIDTH(AW),
    .AXI_LITE_DATA_WIDTH(DW),
    .CFG_BASE           (32'h0),
    .MAX_POLLS          (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_min_i(req_min),
    .req_addr_max_i(req_max),
    .done_o        (done),
    .err_o         (err),
    .axi           (axi)
  );

  always #5 clk = ~clk;

  // Target configuration (written only by the test tasks).
  int aw_delay = 0;
  int w_delay = 0;
  int busy_num = 0;
  int busy_base = 0;
  int err_on_b = -1;
  bit always_busy = 1'b0;

  // Target state and monitor counters (written only by the target process).
  int aw_wait = 0, w_wait = 0;
  bit aw_got = 0, w_got = 0, pending_r = 0;
  bit aw_f = 0, w_f = 0, b_f = 0, ar_f = 0, r_f = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, b_issue = 0, ar_cnt = 0, r_issue = 0, r_cnt = 0;
  int done_cnt = 0, aw_hi = 0, w_hi = 0, overlap = 0;
  logic [AW-1:0]   aw_log [64];
  logic [DW-1:0]   w_log  [64];
  logic [AW-1:0]   ar_last = '0;
  logic [DW/8-1:0] strb_last = '0;
  bit              last_err = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      axi.aw_ready = 1'b0;
      axi.w_ready  = 1'b0;
      axi.ar_ready = 1'b0;
      axi.b_valid  = 1'b0;
      axi.b_resp   = RespOkay;
      axi.r_valid  = 1'b0;
      axi.r_resp   = RespOkay;
      axi.r_data   = '0;
      aw_got = 0; w_got = 0; pending_r = 0;
      aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0;
      aw_wait = 0; w_wait = 0;
    end else begin
      if (aw_f) begin aw_got = 1; aw_wait = 0; end
      if (w_f) begin w_got = 1; w_wait = 0; end
      if (b_f) begin axi.b_valid = 1'b0; aw_got = 0; w_got = 0; end
      if (ar_f) pending_r = 1;
      if (r_f) axi.r_valid = 1'b0;

      if (aw_got && w_got && !axi.b_valid) begin
        axi.b_valid = 1'b1;
        axi.b_resp  = (b_issue == err_on_b) ? RespSlverr : RespOkay;
        b_issue++;
      end

      if (axi.aw_valid && !aw_got) begin
        aw_wait++;
        axi.aw_ready = (aw_wait > aw_delay);
      end else begin
        axi.aw_ready = 1'b0;
        aw_wait = 0;
      end
      if (axi.w_valid && !w_got) begin
        w_wait++;
        axi.w_ready = (w_wait > w_delay);
      end else begin
        axi.w_ready = 1'b0;
        w_wait = 0;
      end
      axi.ar_ready = axi.ar_valid;

      if (pending_r && !axi.r_valid) begin
        axi.r_valid = 1'b1;
        axi.r_resp  = RespOkay;
        axi.r_data  = (always_busy || ((r_issue - busy_base) < busy_num)) ? 64'd1 : 64'd0;
        r_issue++;
        pending_r = 0;
      end

      aw_f = axi.aw_valid && axi.aw_ready;
      w_f  = axi.w_valid && axi.w_ready;
      b_f  = axi.b_valid && axi.b_ready;
      ar_f = axi.ar_valid && axi.ar_ready;
      r_f  = axi.r_valid && axi.r_ready;
      if (aw_f) begin aw_log[aw_cnt % 64] = axi.aw_addr; aw_cnt++; end
      if (w_f) begin w_log[w_cnt % 64] = axi.w_data; strb_last = axi.w_strb; w_cnt++; end
      if (b_f) b_cnt++;
      if (ar_f) begin ar_last = axi.ar_addr; ar_cnt++; end
      if (r_f) r_cnt++;
      if (axi.aw_valid) aw_hi++;
      if (axi.w_valid) w_hi++;
      if (axi.aw_valid && axi.ar_valid) overlap++;
      if (done) begin done_cnt++; last_err = err; end
    end
  end

  task automatic send_req(input logic [DW-1:0] mn, input logic [DW-1:0] mx);
    @(negedge clk);
    req_min   = mn;
    req_max   = mx;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL %s: no done_o within %0d cycles", tag, budget);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    total++;
    if ({axi.aw_valid, axi.w_valid, axi.b_ready, axi.ar_valid, axi.r_ready, done, err}
        !== 7'b0) begin
      bad++;
      $display("FAIL reset_outs: got %b want 0000000", {axi.aw_valid, axi.w_valid,
               axi.b_ready, axi.ar_valid, axi.r_ready, done, err});
    end
  endtask

  task automatic test_basic();
    int aw0 = aw_cnt, w0 = w_cnt, ar0 = ar_cnt, d0 = done_cnt;
    send_req(64'h1000, 64'h1FFF);
    wait_done(d0, 200, "basic_done");
    total++;
    if (aw_cnt - aw0 !== 2) begin bad++; $display("FAIL basic_aw_n: got %0d want 2", aw_cnt - aw0); end
    total++;
    if (aw_log[aw0 % 64] !== 32'h08) begin
      bad++; $display("FAIL basic_aw0: got %h want 08", aw_log[aw0 % 64]);
    end
    total++;
    if (aw_log[(aw0 + 1) % 64] !== 32'h10) begin
      bad++; $display("FAIL basic_aw1: got %h want 10", aw_log[(aw0 + 1) % 64]);
    end
    total++;
    if (w_log[w0 % 64] !== 64'h1000) begin
      bad++; $display("FAIL basic_w0: got %h want 1000", w_log[w0 % 64]);
    end
    total++;
    if (w_log[(w0 + 1) % 64] !== 64'h1FFF) begin
      bad++; $display("FAIL basic_w1: got %h want 1fff", w_log[(w0 + 1) % 64]);
    end
    total++;
    if (strb_last !== 8'hFF) begin bad++; $display("FAIL basic_strb: got %h want ff", strb_last); end
    total++;
    if (ar_cnt - ar0 !== 1) begin bad++; $display("FAIL basic_ar_n: got %0d want 1", ar_cnt - ar0); end
    total++;
    if (ar_last !== 32'h18) begin bad++; $display("FAIL basic_ar_addr: got %h want 18", ar_last); end
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++; $display("FAIL basic_done_n: got %0d want 1", done_cnt - d0);
    end
    total++;
    if (last_err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", last_err); end
  endtask

  task automatic test_aw_delay();
    int awh0 = aw_hi, wh0 = w_hi, b0 = b_cnt, d0 = done_cnt;
    aw_delay = 3;
    send_req(64'h4000, 64'h4FFF);
    wait_done(d0, 200, "awdly_done");
    aw_delay = 0;
    total++;
    if (aw_hi - awh0 !== 8) begin bad++; $display("FAIL awdly_aw_hi: got %0d want 8", aw_hi - awh0); end
    total++;
    if (w_hi - wh0 !== 2) begin bad++; $display("FAIL awdly_w_hi: got %0d want 2", w_hi - wh0); end
    total++;
    if (b_cnt - b0 !== 2) begin bad++; $display("FAIL awdly_b_n: got %0d want 2", b_cnt - b0); end
    total++;
    if (last_err !== 1'b0) begin bad++; $display("FAIL awdly_err: got %b want 0", last_err); end
  endtask

  task automatic test_busy_poll();
    int ar0 = ar_cnt, r0 = r_cnt, d0 = done_cnt;
    busy_base = r_issue;
    busy_num  = 5;
    send_req(64'h5000, 64'h5FFF);
    wait_done(d0, 300, "poll_done");
    busy_num = 0;
    total++;
    if (ar_cnt - ar0 !== 6) begin bad++; $display("FAIL poll_ar_n: got %0d want 6", ar_cnt - ar0); end
    total++;
    if (r_cnt - r0 !== 6) begin bad++; $display("FAIL poll_r_n: got %0d want 6", r_cnt - r0); end
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL poll_done_n: got %0d want 1", done_cnt - d0); end
    total++;
    if (last_err !== 1'b0) begin bad++; $display("FAIL poll_err: got %b want 0", last_err); end
  endtask

  task automatic test_wr_err();
    int aw0 = aw_cnt, ar0 = ar_cnt, d0 = done_cnt;
    err_on_b = b_issue;
    send_req(64'h3000, 64'h3FFF);
    wait_done(d0, 200, "wrerr_done");
    err_on_b = -1;
    total++;
    if (aw_cnt - aw0 !== 1) begin bad++; $display("FAIL wrerr_aw_n: got %0d want 1", aw_cnt - aw0); end
    total++;
    if (ar_cnt - ar0 !== 0) begin bad++; $display("FAIL wrerr_ar_n: got %0d want 0", ar_cnt - ar0); end
    total++;
    if (last_err !== 1'b1) begin bad++; $display("FAIL wrerr_err: got %b want 1", last_err); end
  endtask

  task automatic test_bad_range();
    int aw0 = aw_cnt, w0 = w_cnt, ar0 = ar_cnt, d0 = done_cnt;
    send_req(64'h2000, 64'h1000);
    wait_done(d0, 1, "range_done");
    total++;
    if ((aw_cnt - aw0) + (w_cnt - w0) + (ar_cnt - ar0) !== 0) begin
      bad++; $display("FAIL range_traffic: got %0d handshakes want 0",
                      (aw_cnt - aw0) + (w_cnt - w0) + (ar_cnt - ar0));
    end
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL range_done_n: got %0d want 1", done_cnt - d0); end
    total++;
    if (last_err !== 1'b1) begin bad++; $display("FAIL range_err: got %b want 1", last_err); end
  endtask

`ifdef RAB_INV_TIMEOUT_EN
  task automatic test_timeout();
    int r0 = r_cnt, d0 = done_cnt;
    always_busy = 1'b1;
    send_req(64'h6000, 64'h6FFF);
    wait_done(d0, 300, "tmo_done");
    always_busy = 1'b0;
    total++;
    if (r_cnt - r0 !== 4) begin bad++; $display("FAIL tmo_r_n: got %0d want 4", r_cnt - r0); end
    total++;
    if (last_err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", last_err); end
  endtask
`endif

  task automatic test_reset_mid();
    int d0 = done_cnt;
    int aw0;
    int n = 0;
    busy_base = r_issue;
    busy_num  = 1000;
    send_req(64'h7000, 64'h7FFF);
    while (axi.r_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (axi.r_ready !== 1'b1) begin bad++; $display("FAIL rstmid_reach: r_ready=%b want 1", axi.r_ready); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready, done} !== 6'b0) begin
      bad++;
      $display("FAIL rstmid_outs: got %b want 000000", {axi.aw_valid, axi.w_valid,
               axi.ar_valid, axi.b_ready, axi.r_ready, done});
    end
    @(negedge clk);
    rst_n    = 1'b1;
    busy_num = 0;
    repeat (5) @(posedge clk);
    total++;
    if (done_cnt - d0 !== 0) begin bad++; $display("FAIL rstmid_nodone: got %0d want 0", done_cnt - d0); end
    d0  = done_cnt;
    aw0 = aw_cnt;
    send_req(64'h8000, 64'h8FFF);
    wait_done(d0, 200, "rstmid_after_done");
    total++;
    if (aw_cnt - aw0 !== 2) begin bad++; $display("FAIL rstmid_aw_n: got %0d want 2", aw_cnt - aw0); end
    total++;
    if (last_err !== 1'b0) begin bad++; $display("FAIL rstmid_err: got %b want 0", last_err); end
  endtask

  initial begin
    req_valid = 1'b0;
    req_min   = '0;
    req_max   = '0;
    test_reset();
    test_basic();
    test_aw_delay();
    test_busy_poll();
    test_wr_err();
    test_bad_range();
`ifdef RAB_INV_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    total++;
    if (overlap !== 0) begin bad++; $display("FAIL ar_aw_overlap: got %0d want 0", overlap); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rab_inv_req.md
RAB_INV_REQ -- requirements
Module: rab_inv_req

Interface
REQ-001 SHALL have parameter AXI_LITE_ADDR_WIDTH, default 32, config-port address width.
REQ-002 SHALL have parameter AXI_LITE_DATA_WIDTH, default 64, config-port data width (32 or 64).
REQ-003 SHALL have parameter CFG_BASE, default 0, base address of RAB config space.
REQ-004 SHALL have parameter MAX_POLLS, default 1024, status-poll limit (used only with timeout feature).
REQ-005 SHALL have ports clk_i  in  1  single clock; rst_ni  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports req_valid_i  in  1; req_ready_o  out  1; req_addr_min_i  in  AXI_LITE_DATA_WIDTH; req_addr_max_i  in  AXI_LITE_DATA_WIDTH  (inclusive invalidation range).
REQ-007 SHALL have ports done_o  out  1  one-cycle completion pulse; err_o  out  1  valid with done_o.
REQ-008 SHALL have AXI-Lite master ports aw_addr/aw_valid/aw_ready, w_data/w_strb/w_valid/w_ready, b_resp/b_valid/b_ready, ar_addr/ar_valid/ar_ready, r_data/r_resp/r_valid/r_ready with standard widths and directions for the initiator side.

Function
REQ-009 SHALL implement FSM states IDLE, WR_MIN, WR_MAX, RD_STAT, WAIT_R, DONE.
REQ-010 SHALL assert req_ready_o only in IDLE; on req_valid_i && req_ready_o, capture min/max and go to WR_MIN next cycle.
REQ-011 SHALL in WR_MIN write req_addr_min to CFG_BASE+INV_MIN_OFS, then in WR_MAX write req_addr_max to CFG_BASE+INV_MAX_OFS; writing MAX triggers invalidation in the RAB.
REQ-012 SHALL assert aw_valid and w_valid in the same cycle on write-state entry; each SHALL drop the cycle after its own handshake, independently; w_strb all-ones.
REQ-013 SHALL assert b_ready from write-state entry until B handshake; state advances only after both AW and W handshakes and the B handshake, accepting B arriving in the same cycle as the last AW/W handshake.
REQ-014 SHALL hold aw_addr/w_data stable while the corresponding valid is high (no valid withdrawal).
REQ-015 SHALL on b_resp != OKAY set a sticky error flag and skip directly to DONE.
REQ-016 SHALL in RD_STAT issue ar_valid at CFG_BASE+INV_STATUS_OFS until ar_ready, then go to WAIT_R with r_ready high.
REQ-017 SHALL on R handshake: r_resp != OKAY -> set error, DONE; r_data[0]==1 (busy) -> RD_STAT next cycle; else DONE.
REQ-018 SHALL in DONE pulse done_o for exactly one cycle with err_o = sticky error, then return to IDLE and clear error.
REQ-019 SHALL treat req_addr_min > req_addr_max as error: no AXI traffic, DONE one cycle after acceptance, err_o=1.
REQ-020 SHALL keep at most one outstanding AXI-Lite transaction; never assert ar_valid and aw_valid together.

Reset
REQ-021 SHALL on rst_ni low at a clk_i edge enter IDLE; all valids, b_ready, r_ready, done_o, err_o = 0; req_ready_o = 1 after reset release.
REQ-022 SHALL abandon any in-flight transaction on reset mid-operation without a done_o pulse.

Configuration
REQ-023 SHALL with RAB_INV_TIMEOUT_EN defined count busy reads per request; on the MAX_POLLS-th busy read go to DONE with err_o=1; counter clears in IDLE.
REQ-024 SHALL without RAB_INV_TIMEOUT_EN poll indefinitely, and MAX_POLLS SHALL be unused and no counter instantiated.

Structure
REQ-025 SHALL place INV_MIN_OFS=0x08, INV_MAX_OFS=0x10, INV_STATUS_OFS=0x18, the FSM state enum, and AXI resp constants in package rab_inv_pkg.
REQ-026 SHALL factor the AW/W/B write sequencing into sub-module rab_lite_wr_seq (start, addr, data in; done, err out).

Verification
REQ-027 SHALL cover: min=0x1000, max=0x1FFF, ready always high, status idle -> writes to 0x08 then 0x10, one read at 0x18, done_o with err_o=0.
REQ-028 SHALL cover: aw_ready delayed 3 cycles, w_ready immediate -> w_valid drops after 1 cycle, aw_valid held 4 cycles, single B accepted.
REQ-029 SHALL cover: status busy for 5 reads then idle -> exactly 6 AR handshakes, done_o once, err_o=0.
REQ-030 SHALL cover: b_resp=SLVERR on MIN write -> no MAX write, no AR, done_o with err_o=1; min=0x2000 > max=0x1000 -> zero AXI traffic, err_o=1.
REQ-031 SHALL cover: with RAB_INV_TIMEOUT_EN, MAX_POLLS=4, status always busy -> 4 reads, err_o=1.
REQ-032 SHALL cover: rst_ni low during WAIT_R -> all valids 0 next cycle, no done_o, next request completes normally.
